// File: rtl/conv_pkg.sv
// conv_pkg: shared frame-controller state encoding and default drain length
package conv_pkg;
   localparam int DRAIN_DEFAULT = 4;
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, FINISH, ERR} state_t;
endpackage

// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if: source stream, convolution engine and result-write signals of the frame controller
interface conv_frame_ctrl_if #(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE = 540,
   parameter int NUM_ROWS = 540
);
   import conv_pkg::*;
   localparam int AW = $clog2(ROW_SIZE*NUM_ROWS);
   logic [WORD_SIZE-1:0] src_pixel;
   logic src_valid;
   logic src_ready;
   logic conv_rst;
   logic [WORD_SIZE-1:0] conv_pixel;
   logic [WORD_SIZE-1:0] conv_out;
   logic [1:0] conv_valid;
   logic [WORD_SIZE-1:0] dst_pixel;
   logic [AW-1:0] dst_addr;
   logic dst_valid;
   modport master (
      input src_pixel, src_valid, conv_out, conv_valid,
      output src_ready, conv_rst, conv_pixel, dst_pixel, dst_addr, dst_valid
   );
   modport slave (
      output src_pixel, src_valid, conv_out, conv_valid,
      input src_ready, conv_rst, conv_pixel, dst_pixel, dst_addr, dst_valid
   );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: feeds one frame into a stall-less convolution engine, flushes its pipeline and writes results
module conv_frame_ctrl
   import conv_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE = 540,
   parameter int NUM_ROWS = 540,
   parameter int DRAIN_CYCLES = DRAIN_DEFAULT
) (
   input logic clk,
   input logic rst,
   input logic start,
   conv_frame_ctrl_if.master bus,
   output logic busy,
   output logic done,
   output logic error
);
   localparam int NPIX = ROW_SIZE*NUM_ROWS;
   localparam int AW = $clog2(NPIX);
   localparam int CW = $clog2(NPIX+1);
   localparam int DW = $clog2(DRAIN_CYCLES+1);
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [DW-1:0] dcnt;
   logic [AW-1:0] widx;
   logic accept, last, drained, capture;
   always_comb begin
      accept = state == FEED && bus.src_valid;
      last = accept && cnt == CW'(NPIX-1);
      drained = state == DRAIN && dcnt == DW'(DRAIN_CYCLES-1);
      capture = (state == FEED || state == DRAIN) && bus.conv_valid != '0;
      nxt = state;
      case (state)
         IDLE:    nxt = start ? CLEAR : IDLE;
         CLEAR:   nxt = FEED;
         FEED:    nxt = !bus.src_valid ? ERR : last ? DRAIN : FEED;
         DRAIN:   nxt = drained ? FINISH : DRAIN;
         default: nxt = IDLE;
      endcase
   end
   assign bus.src_ready = state == FEED;
   assign bus.conv_rst = rst || state == CLEAR || state == ERR;
   assign busy = state == CLEAR || state == FEED || state == DRAIN || state == FINISH;
   assign done = state == FINISH;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         dcnt <= '0;
         widx <= '0;
         error <= 1'b0;
         bus.conv_pixel <= '0;
         bus.dst_pixel <= '0;
         bus.dst_addr <= '0;
         bus.dst_valid <= 1'b0;
      end else begin
         state <= nxt;
         bus.dst_valid <= capture;
         dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
         if (state == CLEAR) begin
            cnt <= '0;
            widx <= '0;
            bus.dst_addr <= '0;
            error <= 1'b0;
         end
         if (accept) begin
            cnt <= cnt + 1'b1;
            bus.conv_pixel <= bus.src_pixel;
         end
         if (state == FEED && !bus.src_valid) error <= 1'b1;
         // zeros flush the engine pipeline once the last real pixel has been presented
         if (state == DRAIN) bus.conv_pixel <= '0;
         if (capture) begin
            bus.dst_pixel <= bus.conv_out;
            bus.dst_addr <= widx;
            widx <= widx == AW'(NPIX-1) ? widx : widx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: randomized frames checked against a frame-timeline and write-index model
module tb_conv_frame_ctrl;
   localparam int W = 8;
   localparam int R = 5;
   localparam int N = 5;
   localparam int D = 4;
   localparam int NPIX = R*N;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done, error;
   int n_chk = 0;
   int n_fail = 0;
   int wr = 0;
   bit force_cv = 1'b0;
   conv_frame_ctrl_if #(.WORD_SIZE(W), .ROW_SIZE(R), .NUM_ROWS(N)) bus();
   conv_frame_ctrl #(.WORD_SIZE(W), .ROW_SIZE(R), .NUM_ROWS(N), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .busy(busy), .done(done), .error(error)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   // one clock with random engine results; active says the controller should record them
   task automatic cyc(input bit active);
      logic [1:0] cv;
      logic [W-1:0] co;
      bit ev;
      cv = force_cv ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      co = W'($urandom);
      bus.conv_valid = cv;
      bus.conv_out = co;
      ev = active && !rst && cv != 2'd0;
      @(posedge clk);
      #1;
      chk("dst_valid", bus.dst_valid, ev);
      if (ev) begin
         chk("dst_pixel", bus.dst_pixel, co);
         chk("dst_addr", bus.dst_addr, wr < NPIX-1 ? wr : NPIX-1);
         wr++;
      end
   endtask
   task automatic reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_src_ready"}, bus.src_ready, 0);
      chk({tag, "_conv_pixel"}, bus.conv_pixel, 0);
      chk({tag, "_dst_pixel"}, bus.dst_pixel, 0);
      chk({tag, "_dst_addr"}, bus.dst_addr, 0);
      chk({tag, "_conv_rst"}, bus.conv_rst, 1);
   endtask
   task automatic frame(input int drop_at, input int rst_at, input bit poke);
      logic [W-1:0] pix, last;
      last = '0;
      wr = 0;
      start = 1'b1;
      cyc(0);
      start = 1'b0;
      chk("clear_conv_rst", bus.conv_rst, 1);
      chk("clear_busy", busy, 1);
      chk("clear_src_ready", bus.src_ready, 0);
      bus.src_valid = 1'b1;
      bus.src_pixel = W'($urandom);
      cyc(0);
      chk("feed_error_cleared", error, 0);
      chk("feed_dst_addr_cleared", bus.dst_addr, 0);
      for (int p = 0; p < NPIX; p++) begin
         chk("feed_src_ready", bus.src_ready, 1);
         chk("feed_busy", busy, 1);
         chk("feed_conv_rst", bus.conv_rst, 0);
         chk("feed_done", done, 0);
         if (p == drop_at) begin
            bus.src_valid = 1'b0;
            cyc(1);
            chk("err_error", error, 1);
            chk("err_conv_rst", bus.conv_rst, 1);
            chk("err_busy", busy, 0);
            chk("err_src_ready", bus.src_ready, 0);
            chk("err_conv_pixel_held", bus.conv_pixel, last);
            cyc(0);
            chk("err_idle_conv_rst", bus.conv_rst, 0);
            chk("err_idle_error_sticky", error, 1);
            chk("err_idle_busy", busy, 0);
            return;
         end
         if (p == rst_at) begin
            rst = 1'b1;
            cyc(0);
            reset_vals("midrst");
            rst = 1'b0;
            bus.src_valid = 1'b0;
            cyc(0);
            chk("midrst_idle_conv_rst", bus.conv_rst, 0);
            chk("midrst_idle_busy", busy, 0);
            return;
         end
         pix = W'($urandom);
         bus.src_pixel = pix;
         start = poke ? 1'($urandom) : 1'b0;
         cyc(1);
         last = pix;
         chk("feed_conv_pixel", bus.conv_pixel, pix);
      end
      start = 1'b0;
      bus.src_valid = 1'b0;
      for (int d = 0; d < D; d++) begin
         chk("drain_src_ready", bus.src_ready, 0);
         chk("drain_busy", busy, 1);
         chk("drain_done", done, 0);
         chk("drain_conv_rst", bus.conv_rst, 0);
         if (d > 0) chk("drain_conv_pixel", bus.conv_pixel, 0);
         cyc(1);
      end
      chk("finish_done", done, 1);
      chk("finish_busy", busy, 1);
      chk("finish_conv_pixel", bus.conv_pixel, 0);
      cyc(0);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_error", error, 0);
      if (force_cv) chk("sat_dst_addr", bus.dst_addr, NPIX-1);
   endtask
   initial begin
      bus.src_valid = 1'b0;
      bus.src_pixel = '0;
      bus.conv_valid = '0;
      bus.conv_out = '0;
      cyc(0);
      cyc(0);
      reset_vals("reset");
      rst = 1'b0;
      cyc(0);
      chk("idle_conv_rst", bus.conv_rst, 0);
      frame(-1, -1, 1'b0);
      cyc(0);
      frame(-1, -1, 1'b1);
      cyc(0);
      frame(7, -1, 1'b0);
      cyc(0);
      frame(-1, -1, 1'b0);
      frame(-1, 15, 1'b0);
      frame(-1, -1, 1'b0);
      force_cv = 1'b1;
      frame(-1, -1, 1'b0);
      force_cv = 1'b0;
      cyc(0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
